// File: rtl/vga_pkg.sv
// Shared VGA pipeline types and defaults.
// The sprite stage uses vga_timing_t as the payload it delays alongside the ROM fetch.
package vga_pkg;

    localparam int          SPRITE_W_DEF = 64;
    localparam int          SPRITE_H_DEF = 64;
    localparam logic [11:0] KEY_RGB_DEF  = 12'hF0F;

    typedef struct packed {
        logic [11:0] hcount;
        logic [11:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_timing_t;

    // A 1x1 sprite would otherwise give a zero-width address bus.
    function automatic int addr_width(input int w, input int h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

endpackage

// File: rtl/vga_if.sv
// One VGA pipeline link: timing counters, syncs, blanking and pixel colour.
// in/out are the stage-facing views; master/slave are aliases for generic producers/consumers.
interface vga_if;

    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_delay.sv
// Fixed-depth shift register with synchronous reset; every stage clears on rst.
// Used to keep the timing payload aligned with the external ROM read data.
module vga_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] d;

        if (gi == 0) begin : g_head
            assign d = din_i;
        end else begin : g_tail
            assign d = g_stage[gi-1].q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end

    assign dout_o = g_stage[DEPTH-1].q;

endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: frame-latched position, integer-scaled ROM fetch, optional colour key.
// vga_out lags vga_in by ROM_LATENCY+1 cycles; the final colour mux is combinational on rgb_pixel.
module draw_sprite
    import vga_pkg::*;
#(
    parameter int          SPRITE_W    = SPRITE_W_DEF,
    parameter int          SPRITE_H    = SPRITE_H_DEF,
    parameter int          SCALE_LOG2  = 0,
    parameter int          ROM_LATENCY = 1,
    parameter int          TRANSP_EN   = 1,
    parameter logic [11:0] KEY_RGB     = KEY_RGB_DEF,
    parameter int          ADDR_W      = addr_width(SPRITE_W, SPRITE_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       xpos,
    input  logic [11:0]       ypos,
    input  logic              en,
    input  logic [11:0]       rgb_pixel,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              pos_latched,
    vga_if.in                 vga_in,
    vga_if.out                vga_out
);

    localparam int X_BITS = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 0;
    localparam int FOOT_W = SPRITE_W << SCALE_LOG2;
    localparam int FOOT_H = SPRITE_H << SCALE_LOG2;
    localparam int DEPTH  = ROM_LATENCY + 1;
    localparam int TW     = $bits(vga_timing_t);

    logic [11:0]       x_s_q;
    logic [11:0]       y_s_q;
    logic              en_s_q;
    logic              vblnk_prev_q;
    logic              pos_latched_q;
    logic [ADDR_W-1:0] pixel_addr_q;
    logic [ADDR_W-1:0] pixel_addr_d;
    logic              vblnk_rise;

    assign vblnk_rise = vga_in.vblnk & ~vblnk_prev_q;

    // Shadow position only moves at the start of vertical blanking so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_s_q         <= '0;
            y_s_q         <= '0;
            en_s_q        <= 1'b0;
            vblnk_prev_q  <= 1'b0;
            pos_latched_q <= 1'b0;
            pixel_addr_q  <= '0;
        end else begin
            vblnk_prev_q  <= vga_in.vblnk;
            pos_latched_q <= vblnk_rise;
            pixel_addr_q  <= pixel_addr_d;
            if (vblnk_rise) begin
                x_s_q  <= xpos;
                y_s_q  <= ypos;
                en_s_q <= en;
            end
        end
    end

    assign pos_latched = pos_latched_q;
    assign pixel_addr  = pixel_addr_q;

    logic signed [12:0] dx;
    logic signed [12:0] dy;
    logic [11:0]        sx;
    logic [11:0]        sy;
    logic               hit;

    // 13-bit signed differences: a sprite hanging off the right edge never wraps to column 0.
    assign dx = $signed({1'b0, vga_in.hcount}) - $signed({1'b0, x_s_q});
    assign dy = $signed({1'b0, vga_in.vcount}) - $signed({1'b0, y_s_q});
    assign sx = dx[11:0] >> SCALE_LOG2;
    assign sy = dy[11:0] >> SCALE_LOG2;

    assign hit = en_s_q & ~vga_in.hblnk & ~vga_in.vblnk
               & ~dx[12] & (dx[11:0] < 12'(FOOT_W))
               & ~dy[12] & (dy[11:0] < 12'(FOOT_H));

    assign pixel_addr_d = hit ? ADDR_W'((32'(sy) << X_BITS) | 32'(sx)) : '0;

    vga_timing_t     t_in;
    vga_timing_t     t_out;
    logic [TW:0]     dl_in;
    logic [TW:0]     dl_out;
    logic            hit_d;
    logic            is_key;

    assign t_in = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                    hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                    hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk,
                    rgb:    vga_in.rgb};
    assign dl_in = {t_in, hit};

    vga_delay #(
        .DEPTH (DEPTH),
        .WIDTH (TW + 1)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .din_i  (dl_in),
        .dout_o (dl_out)
    );

    assign t_out  = dl_out[TW:1];
    assign hit_d  = dl_out[0];
    assign is_key = (TRANSP_EN != 0) && (rgb_pixel == KEY_RGB);

    assign vga_out.hcount = t_out.hcount;
    assign vga_out.vcount = t_out.vcount;
    assign vga_out.hsync  = t_out.hsync;
    assign vga_out.vsync  = t_out.vsync;
    assign vga_out.hblnk  = t_out.hblnk;
    assign vga_out.vblnk  = t_out.vblnk;
    assign vga_out.rgb    = (hit_d && !is_key) ? rgb_pixel : t_out.rgb;

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite: four instances (default, unkeyed, 8x8 scaled, latency 3)
// share one upstream stream; each has its own position inputs and ROM model.
module tb_draw_sprite;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [11:0] rom0 = 12'h000;
    logic [11:0] xpos_a = '0, ypos_a = '0, xpos_c = '0, ypos_c = '0, xpos_d = '0, ypos_d = '0;
    logic        en_a = 1'b0, en_c = 1'b0, en_d = 1'b0;

    logic [11:0] addr_a, addr_b, addr_d;
    logic [5:0]  addr_c;
    logic        pl_a, pl_b, pl_c, pl_d;
    logic [11:0] rgb_a, rgb_b, rgb_c, rgb_d, d1, d2;

    vga_if vin();
    vga_if vout_a();
    vga_if vout_b();
    vga_if vout_c();
    vga_if vout_d();

    draw_sprite u_a (.clk(clk), .rst(rst), .xpos(xpos_a), .ypos(ypos_a), .en(en_a),
                     .rgb_pixel(rgb_a), .pixel_addr(addr_a), .pos_latched(pl_a),
                     .vga_in(vin), .vga_out(vout_a));

    draw_sprite #(.TRANSP_EN(0)) u_b (.clk(clk), .rst(rst), .xpos(xpos_a), .ypos(ypos_a), .en(en_a),
                     .rgb_pixel(rgb_b), .pixel_addr(addr_b), .pos_latched(pl_b),
                     .vga_in(vin), .vga_out(vout_b));

    draw_sprite #(.SPRITE_W(8), .SPRITE_H(8), .SCALE_LOG2(1)) u_c (.clk(clk), .rst(rst),
                     .xpos(xpos_c), .ypos(ypos_c), .en(en_c),
                     .rgb_pixel(rgb_c), .pixel_addr(addr_c), .pos_latched(pl_c),
                     .vga_in(vin), .vga_out(vout_c));

    draw_sprite #(.ROM_LATENCY(3)) u_d (.clk(clk), .rst(rst), .xpos(xpos_d), .ypos(ypos_d), .en(en_d),
                     .rgb_pixel(rgb_d), .pixel_addr(addr_d), .pos_latched(pl_d),
                     .vga_in(vin), .vga_out(vout_d));

    // ROM image: address itself as colour, except address 0 which is programmable.
    function automatic logic [11:0] rom_f(input logic [11:0] a);
        return (a == 12'd0) ? rom0 : a;
    endfunction

    always @(posedge clk) begin
        rgb_a <= rom_f(addr_a);
        rgb_b <= rom_f(addr_b);
        rgb_c <= rom_f({6'd0, addr_c});
        d1    <= rom_f(addr_d);
        d2    <= d1;
        rgb_d <= d2;
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [11:0] h, input logic [11:0] v, input logic hs, input logic vs,
                         input logic hb, input logic vb, input logic [11:0] c);
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic filler();
        drive(12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    endtask

    // Present one pixel for a single cycle; returns one cycle later with filler on the input.
    task automatic px(input logic [11:0] h, input logic [11:0] v, input logic hb, input logic [11:0] c);
        drive(h, v, 1'b0, 1'b0, hb, 1'b0, c);
        tick();
        filler();
    endtask

    task automatic vblank_pulse();
        drive(12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        tick();
    endtask

    initial begin
        drive(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        repeat (3) tick();
        chk("reset_vga_out", {vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.vsync,
                              vout_a.hblnk, vout_a.vblnk, vout_a.rgb}, 48'd0);
        chk("reset_addr", {36'd0, addr_a}, 48'd0);
        chk("reset_pos_latched", {47'd0, pl_a}, 48'd0);

        rst = 1'b0;
        xpos_a = 12'd100; ypos_a = 12'd50;  en_a = 1'b1;
        xpos_c = 12'd0;   ypos_c = 12'd0;   en_c = 1'b1;
        xpos_d = 12'd780; ypos_d = 12'd10;  en_d = 1'b1;
        filler();
        tick();

        // First vblank: shadow load and single-cycle pulse.
        vblank_pulse();
        chk("latch1_pulse", {47'd0, pl_a}, 48'd1);
        tick();
        chk("latch1_pulse_end", {47'd0, pl_a}, 48'd0);
        filler();
        repeat (4) tick();

        // Default instance, opaque, ROM_LATENCY=1.
        px(12'd100, 12'd50, 1'b0, 12'h123);
        chk("a_addr_100_50", {36'd0, addr_a}, 48'd0);
        tick();
        chk("a_rgb_100_50", {36'd0, vout_a.rgb}, 48'h000);
        chk("a_hcount_align", {36'd0, vout_a.hcount}, 48'd100);
        chk("a_vcount_align", {36'd0, vout_a.vcount}, 48'd50);

        px(12'd163, 12'd113, 1'b0, 12'h123);
        chk("a_addr_163_113", {36'd0, addr_a}, 48'd4095);
        tick();
        chk("a_rgb_163_113", {36'd0, vout_a.rgb}, 48'hFFF);

        px(12'd164, 12'd50, 1'b0, 12'h456);
        chk("a_addr_164_50", {36'd0, addr_a}, 48'd0);
        tick();
        chk("a_rgb_164_50", {36'd0, vout_a.rgb}, 48'h456);

        px(12'd99, 12'd50, 1'b0, 12'h789);
        tick();
        chk("a_rgb_99_50", {36'd0, vout_a.rgb}, 48'h789);

        // Sync latency: 2 cycles on the default instance, 4 on the latency-3 instance.
        drive(12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
        tick();
        filler();
        chk("a_hsync_c1", {47'd0, vout_a.hsync}, 48'd0);
        tick();
        chk("a_hsync_c2", {46'd0, vout_a.hsync, vout_a.vsync}, 48'd3);
        tick();
        chk("a_hsync_c3", {47'd0, vout_a.hsync}, 48'd0);
        chk("d_hsync_c3", {47'd0, vout_d.hsync}, 48'd0);
        tick();
        chk("d_sync_c4", {46'd0, vout_d.hsync, vout_d.vsync}, 48'd3);
        tick();
        chk("d_hsync_c5", {47'd0, vout_d.hsync}, 48'd0);

        // Transparency key at address 0.
        rom0 = 12'hF0F;
        px(12'd100, 12'd50, 1'b0, 12'h0A0);
        tick();
        chk("a_key_shows_bg", {36'd0, vout_a.rgb}, 48'h0A0);
        chk("b_nokey_shows_rom", {36'd0, vout_b.rgb}, 48'hF0F);
        rom0 = 12'h000;
        tick();

        // 8x8 sprite at 2x scale.
        px(12'd0, 12'd0, 1'b0, 12'h321);
        chk("c_addr_0_0", {42'd0, addr_c}, 48'd0);
        tick();
        chk("c_rgb_0_0", {36'd0, vout_c.rgb}, 48'h000);
        px(12'd1, 12'd1, 1'b0, 12'h321);
        chk("c_addr_1_1", {42'd0, addr_c}, 48'd0);
        px(12'd0, 12'd1, 1'b0, 12'h321);
        chk("c_addr_0_1", {42'd0, addr_c}, 48'd0);
        px(12'd15, 12'd15, 1'b0, 12'h321);
        chk("c_addr_15_15", {42'd0, addr_c}, 48'd63);
        tick();
        chk("c_rgb_15_15", {36'd0, vout_c.rgb}, 48'h03F);
        px(12'd2, 12'd0, 1'b0, 12'h321);
        chk("c_addr_2_0", {42'd0, addr_c}, 48'd1);
        px(12'd16, 12'd0, 1'b0, 12'h321);
        chk("c_addr_16_0", {42'd0, addr_c}, 48'd0);
        tick();
        chk("c_rgb_16_0", {36'd0, vout_c.rgb}, 48'h321);

        // Right-edge clip with ROM_LATENCY=3.
        px(12'd780, 12'd10, 1'b0, 12'h555);
        chk("d_addr_780", {36'd0, addr_d}, 48'd0);
        repeat (3) tick();
        chk("d_rgb_780", {36'd0, vout_d.rgb}, 48'h000);
        px(12'd799, 12'd10, 1'b0, 12'h555);
        chk("d_addr_799", {36'd0, addr_d}, 48'd19);
        repeat (3) tick();
        chk("d_rgb_799", {36'd0, vout_d.rgb}, 48'h013);
        px(12'd779, 12'd10, 1'b0, 12'h555);
        repeat (3) tick();
        chk("d_rgb_779", {36'd0, vout_d.rgb}, 48'h555);
        px(12'd800, 12'd10, 1'b1, 12'h555);
        chk("d_addr_800_blank", {36'd0, addr_d}, 48'd0);
        repeat (3) tick();
        chk("d_rgb_800_blank", {36'd0, vout_d.rgb}, 48'h555);
        px(12'd0, 12'd11, 1'b0, 12'h555);
        chk("d_addr_wrap_0", {36'd0, addr_d}, 48'd0);
        repeat (3) tick();
        chk("d_rgb_wrap_0", {36'd0, vout_d.rgb}, 48'h555);
        px(12'd43, 12'd11, 1'b0, 12'h555);
        chk("d_addr_wrap_43", {36'd0, addr_d}, 48'd0);
        repeat (3) tick();

        // Mid-frame position change is ignored until the next vblank.
        xpos_a = 12'd200;
        px(12'd100, 12'd60, 1'b0, 12'h777);
        chk("latch_hold_addr", {36'd0, addr_a}, 48'd640);
        tick();
        chk("latch_hold_rgb", {36'd0, vout_a.rgb}, 48'h280);
        px(12'd200, 12'd60, 1'b0, 12'h777);
        tick();
        chk("latch_hold_new_pos_bg", {36'd0, vout_a.rgb}, 48'h777);

        xpos_a = 12'd300;
        vblank_pulse();
        chk("latch2_pulse", {47'd0, pl_a}, 48'd1);
        tick();
        chk("latch2_pulse_end", {47'd0, pl_a}, 48'd0);
        tick();
        chk("latch2_pulse_quiet", {47'd0, pl_a}, 48'd0);
        filler();
        repeat (3) tick();

        px(12'd300, 12'd60, 1'b0, 12'h777);
        chk("moved_addr", {36'd0, addr_a}, 48'd640);
        tick();
        chk("moved_rgb", {36'd0, vout_a.rgb}, 48'h280);
        px(12'd100, 12'd60, 1'b0, 12'h777);
        tick();
        chk("moved_old_pos_bg", {36'd0, vout_a.rgb}, 48'h777);

        en_a = 1'b0;
        px(12'd300, 12'd61, 1'b0, 12'h777);
        tick();
        chk("en_drop_still_visible", {36'd0, vout_a.rgb}, 48'h2C0);

        // Mid-line reset: flushed pipeline, sprite hidden until the next vblank.
        en_a = 1'b1;
        px(12'd300, 12'd61, 1'b0, 12'h999);
        drive(12'd300, 12'd61, 1'b1, 1'b1, 1'b0, 1'b0, 12'h999);
        rst = 1'b1;
        tick();
        chk("rst_mid_vga_out", {vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.vsync,
                                vout_a.hblnk, vout_a.vblnk, vout_a.rgb}, 48'd0);
        chk("rst_mid_addr", {36'd0, addr_a}, 48'd0);
        chk("rst_mid_pos_latched", {47'd0, pl_a}, 48'd0);
        rst = 1'b0;
        px(12'd300, 12'd61, 1'b0, 12'h999);
        chk("post_rst_hidden_addr", {36'd0, addr_a}, 48'd0);
        chk("post_rst_black", {36'd0, vout_a.rgb}, 48'h000);
        tick();
        chk("post_rst_hidden_rgb", {36'd0, vout_a.rgb}, 48'h999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
